// File: rtl/keccak_issue_if.sv
// keccak_issue_if: command handshake plus ALU operand/result bus for keccak_issue_unit
interface keccak_issue_if #(parameter int IDX_W = 5);
  logic cmd_valid;
  logic cmd_ready;
  logic [2:0] cmd_mode;
  logic [5*IDX_W-1:0] cmd_rs;
  logic [IDX_W-1:0] cmd_rd;
  logic [319:0] alu_registers;
  logic [2:0] alu_mode;
  logic [63:0] alu_result;
  modport master (
    output cmd_valid, cmd_mode, cmd_rs, cmd_rd, alu_result,
    input cmd_ready, alu_registers, alu_mode
  );
  modport slave (
    input cmd_valid, cmd_mode, cmd_rs, cmd_rd, alu_result,
    output cmd_ready, alu_registers, alu_mode
  );
endinterface

// File: rtl/keccak_issue_unit.sv
// keccak_issue_unit: lane register file issuing one Keccak ALU command per cycle with result forwarding
module keccak_issue_unit #(
  parameter int NREGS = 32,
  parameter int IDX_W = 5
) (
  input  logic clk,
  input  logic rst,
  keccak_issue_if.slave bus,
  input  logic i_wr_en,
  input  logic [IDX_W-1:0] i_wr_addr,
  input  logic [63:0] i_wr_data,
  input  logic [IDX_W-1:0] i_rd_addr,
  output logic [63:0] o_rd_data,
  output logic o_busy,
  output logic [15:0] o_retired
);
  logic [63:0] r_regs [NREGS];
  logic [319:0] r_alu_regs;
  logic [2:0] r_alu_mode;
  logic r_ex_valid;
  logic [IDX_W-1:0] r_ex_rd;
  logic [63:0] r_rd_data;
  logic [15:0] r_retired;
  logic [319:0] w_ops;
  logic w_accept;
  assign bus.cmd_ready = !i_wr_en;
  assign w_accept = bus.cmd_valid && !i_wr_en;
  // the in-flight result is not in the regfile yet, so a matching slot takes it straight off the ALU
  for (genvar k = 0; k < 5; k++) begin : g_op
    logic [IDX_W-1:0] w_idx;
    assign w_idx = bus.cmd_rs[k*IDX_W +: IDX_W];
    assign w_ops[k*64 +: 64] = (r_ex_valid && w_idx == r_ex_rd) ? bus.alu_result : r_regs[w_idx];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_alu_regs <= '0;
      r_alu_mode <= '0;
      r_ex_valid <= 1'b0;
      r_ex_rd <= '0;
      r_rd_data <= '0;
      r_retired <= '0;
    end else begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_alu_regs <= w_ops;
        r_alu_mode <= bus.cmd_mode;
        r_ex_rd <= bus.cmd_rd;
      end
      if (r_ex_valid) begin
        r_regs[r_ex_rd] <= bus.alu_result;
        r_retired <= r_retired + 16'd1;
      end
      // host write comes last so it wins a same-index collision with write-back
      if (i_wr_en) r_regs[i_wr_addr] <= i_wr_data;
      r_rd_data <= r_regs[i_rd_addr];
    end
  end
  assign bus.alu_registers = r_alu_regs;
  assign bus.alu_mode = r_alu_mode;
  assign o_rd_data = r_rd_data;
  assign o_busy = r_ex_valid;
  assign o_retired = r_retired;
endmodule
